// File: rtl/onewire_pkg.sv
// onewire_pkg: shared command codes, bus timing constants and FSM states for the 1-Wire responder
package onewire_pkg;
  localparam logic [7:0] CMD_READ_ROM     = 8'h33;
  localparam logic [7:0] CMD_SKIP_ROM     = 8'hCC;
  localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;
  localparam int RST_MIN_US     = 480;
  localparam int SLOT_SAMPLE_US = 30;
  typedef enum logic [2:0] {
    IDLE, RST_WAIT, PRES_DLY, PRES, RX_ROM, TX_ROM, RX_FUNC, TX_DATA
  } state_t;
endpackage

// File: rtl/onewire_crc8.sv
// onewire_crc8: bit-serial Dallas CRC-8 (x^8+x^5+x^4+1, reflected, init 0) with clear and enable
module onewire_crc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);
  logic fb;
  assign fb = crc[0] ^ din;
  always_ff @(posedge clk)
    if (rst || clr) crc <= '0;
    else if (en) crc <= {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
endmodule

// File: rtl/onewire_slave.sv
// onewire_slave: 1-Wire temperature-sensor emulator (presence, ROM/function decode, ROM/temperature readout).
// Define ONEWIRE_SLAVE_CRC_EN to append a Dallas CRC-8 to the temperature readout.
module onewire_slave #(
  parameter int          CLK_HZ          = 24_000_000,
  parameter logic [63:0] ROM_ID          = 64'h2800_0000_0000_0110,
  parameter int          PRESENCE_DLY_US = 30,
  parameter int          PRESENCE_US     = 120
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_owr,
  output logic        o_owr,
  input  logic [15:0] i_temp,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_vld
);
  import onewire_pkg::*;
  localparam int DIV = CLK_HZ / 1_000_000;
`ifdef ONEWIRE_SLAVE_CRC_EN
  localparam int DATA_LAST = 23;
`else
  localparam int DATA_LAST = 15;
`endif
  state_t      state, nxt;
  logic        s0, s1, prev, fall, rise, tick, rst_det, rx_st, tx_st, chg;
  logic        slot_act, slot_go, slot_done, byte_done, tx_last, owr_d;
  logic [15:0] div, tmr;
  logic [9:0]  low_cnt;
  logic [5:0]  slot_cnt;
  logic [6:0]  bit_cnt;
  logic [7:0]  rx, byte_nxt;
  logic [63:0] tx;
  assign fall      = prev & ~s1;
  assign rise      = ~prev & s1;
  assign tick      = div == 16'(DIV - 1);
  assign rst_det   = low_cnt >= 10'(RST_MIN_US);
  assign rx_st     = state == RX_ROM || state == RX_FUNC;
  assign tx_st     = state == TX_ROM || state == TX_DATA;
  assign chg       = nxt != state;
  assign slot_go   = fall & ~slot_act & (rx_st | tx_st);
  assign slot_done = slot_act & tick & (slot_cnt == 6'(SLOT_SAMPLE_US - 1));
  assign byte_nxt  = {s1, rx[7:1]};
  assign byte_done = rx_st & slot_done & (bit_cnt == 7'd7);
  assign tx_last   = tx_st & slot_done & (bit_cnt == (state == TX_ROM ? 7'd63 : 7'(DATA_LAST)));
  // Sync flops idle high so release of reset never looks like a bus edge
  always_ff @(posedge i_clk)
    if (i_rst) {s0, s1, prev} <= 3'b111;
    else {s0, s1, prev} <= {i_owr, s0, s1};
  always_ff @(posedge i_clk)
    if (i_rst) begin
      div      <= '0;
      low_cnt  <= '0;
      tmr      <= '0;
      slot_act <= 1'b0;
      slot_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      div      <= tick ? '0 : div + 16'd1;
      low_cnt  <= rise ? '0 : (!s1 && tick && low_cnt != 10'd1023) ? low_cnt + 10'd1 : low_cnt;
      tmr      <= chg ? '0 : tick ? tmr + 16'd1 : tmr;
      slot_act <= rst_det ? 1'b0 : slot_go ? 1'b1 : slot_done ? 1'b0 : slot_act;
      slot_cnt <= slot_go ? '0 : (slot_act && tick) ? slot_cnt + 6'd1 : slot_cnt;
      bit_cnt  <= chg ? '0 : slot_done ? bit_cnt + 7'd1 : bit_cnt;
    end
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      RST_WAIT: nxt = rise ? PRES_DLY : RST_WAIT;
      PRES_DLY: nxt = (tick && tmr == 16'(PRESENCE_DLY_US - 1)) ? PRES : PRES_DLY;
      PRES:     nxt = (tick && tmr == 16'(PRESENCE_US - 1)) ? RX_ROM : PRES;
      RX_ROM:   nxt = !byte_done ? RX_ROM : byte_nxt == CMD_READ_ROM ? TX_ROM :
                      byte_nxt == CMD_SKIP_ROM ? RX_FUNC : IDLE;
      RX_FUNC:  nxt = !byte_done ? RX_FUNC : byte_nxt == CMD_READ_SCRATCH ? TX_DATA : IDLE;
      TX_ROM, TX_DATA: nxt = tx_last ? IDLE : state;
      default:  nxt = state;
    endcase
    if (rst_det && !(state == RST_WAIT && rise)) nxt = RST_WAIT;
  end
  // Read slot: pull low at slot start for a 0 bit, hold until the slot timer expires
  always_comb
    owr_d = nxt == PRES || (tx_st && !chg && (slot_go ? ~tx[0] : o_owr & ~slot_done));
`ifdef ONEWIRE_SLAVE_CRC_EN
  logic [7:0] crc;
  logic       crc_ld;
  onewire_crc8 u_crc (
    .clk(i_clk),
    .rst(i_rst),
    .clr(chg && nxt == TX_DATA),
    .en (state == TX_DATA && slot_done && bit_cnt[6:4] == 3'd0),
    .din(tx[0]),
    .crc(crc)
  );
  always_ff @(posedge i_clk)
    crc_ld <= !i_rst && state == TX_DATA && slot_done && bit_cnt == 7'd15;
`endif
  always_ff @(posedge i_clk)
    if (i_rst) begin
      rx        <= '0;
      tx        <= '0;
      o_cmd     <= '0;
      o_cmd_vld <= 1'b0;
      o_owr     <= 1'b0;
    end else begin
      o_owr     <= owr_d;
      o_cmd_vld <= byte_done;
      if (byte_done) o_cmd <= byte_nxt;
      if (rx_st && slot_done) rx <= byte_nxt;
      if (chg && nxt == TX_ROM) tx <= ROM_ID;
      else if (chg && nxt == TX_DATA) tx <= {48'hFFFF_FFFF_FFFF, i_temp};
`ifdef ONEWIRE_SLAVE_CRC_EN
      else if (crc_ld) tx[7:0] <= crc;
`endif
      else if (tx_st && slot_done) tx <= {1'b1, tx[63:1]};
    end
endmodule

// File: doc/onewire_slave.md
# onewire_slave

1-Wire bus responder (device emulator) that answers a 1-Wire master the way a single temperature sensor would. It detects reset pulses and answers with a presence pulse. It then decodes ROM and function commands in write slots and returns the ROM ID or a 16-bit temperature word in read slots. It sits in the chip top level next to the master. This enables loopback bring-up and self-test of the master without a physical sensor, using the same open-drain pin arrangement: the pin pulls low when the drive is 1, and is released otherwise.

## Interface
- `CLK_HZ`, 24_000_000: frequency of `i_clk`; sets the microsecond tick (`CLK_HZ/1_000_000` cycles per µs).
- `ROM_ID`, 64'h2800_0000_0000_0110: 64-bit ROM code returned for READ ROM, LSB first.
- `PRESENCE_DLY_US`, 30: µs from bus release after reset to the start of presence.
- `PRESENCE_US`, 120: presence pulse width in µs.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_owr`  in  1  raw bus level (asynchronous; synchronised internally).
- `o_owr`  out  1  1 = pull bus low, 0 = release.
- `i_temp`  in  16  temperature word; latched when READ SCRATCHPAD is decoded.
- `o_cmd`  out  8  last received command byte.
- `o_cmd_vld`  out  1  one-cycle strobe when `o_cmd` updates.

## Operation
- Input path: 2-flop synchroniser, then falling/rising edge detect on the synchronised level.
- µs prescaler: free-running counter producing a 1-cycle `tick_us`. Reset-mid-slot is not a concern because every slot timer restarts on a falling edge.
- Low-time counter: 10 bits, counts µs while the bus is low, saturates at 1023, clears on a rising edge.
- Reset detection: the low-time counter reaching 480 forces state RST_WAIT from any state. `o_owr` is released, and any TX/RX shift in progress is abandoned.
- States and transitions:
  - IDLE → (falling edges ignored).
  - RST_WAIT → on rising edge go to PRES_DLY.
  - PRES_DLY → after `PRESENCE_DLY_US` µs go to PRES (drive low).
  - PRES → after `PRESENCE_US` µs, release and go to RX_ROM.
  - RX_ROM → after 8 bits:
    - 0x33 → TX_ROM;
    - 0xCC → RX_FUNC;
    - else → IDLE.
  - TX_ROM → after 64 bits go to IDLE.
  - RX_FUNC → after 8 bits:
    - 0xBE → latch `i_temp`, go to TX_DATA;
    - else → IDLE.
  - TX_DATA → after 16 bits (24 with CRC) go to IDLE.
- Write slot (RX states): on a falling edge start a slot timer. At 30 µs, sample the bus: high = 1, low = 0. Shift in LSB first.
- Read slot (TX states): on a falling edge, if the current bit is 0, drive `o_owr`=1 for 30 µs. If the bit is 1, leave the bus released. Advance the bit index at slot end (30 µs). Bits go out LSB first.
- Falling edges during an active slot timer are ignored. Slot timer and bit counter are internal, not exported.
- `o_cmd_vld` pulses for both the ROM command and the function command byte.

## Timing
- Reset values:
  - `o_owr`=0, `o_cmd`=8'h00, `o_cmd_vld`=0;
  - state IDLE; all counters 0.
- Bus-to-decision latency: 2 cycles of synchroniser plus 1 cycle of edge detect.
- `o_owr` is registered; it asserts 1 cycle after the internal decision.
- Sampling point: 30 µs ±1 µs (tick granularity) after the synchronised falling edge.
- `o_cmd_vld` rises in the cycle after the 8th bit is sampled.
- Reset pulses of exactly 480 µs are accepted. Pulses of 479 µs or less do not cause a reset; during RX they read as a 0 bit.

## Configuration
- `ONEWIRE_SLAVE_CRC_EN` defined: TX_DATA appends an 8-bit Dallas CRC (x^8+x^5+x^4+1, init 0) over the two temperature bytes, for 24 bits total.
- Not defined: TX_DATA sends 16 bits and no CRC logic is built.

## Structure
- `onewire_pkg`:
  - command constants (`CMD_READ_ROM`=8'h33, `CMD_SKIP_ROM`=8'hCC, `CMD_READ_SCRATCH`=8'hBE);
  - timing constants (`RST_MIN_US`=480, `SLOT_SAMPLE_US`=30);
  - the state enum.
- Sub-module `onewire_crc8`: a bit-serial CRC with clear and enable. It is instantiated only under `ONEWIRE_SLAVE_CRC_EN`.

## Test plan
- Hold the bus low for 500 µs, then release → `o_owr` rises 30 µs after release and stays high for 120 µs.
- Hold the bus low for 400 µs → no presence pulse; state unchanged.
- Reset, then write 0x33 → `o_cmd`=8'h33 with `o_cmd_vld` pulsing once; 64 read slots return `ROM_ID` LSB first; 0 bits are driven low for 30 µs.
- Reset, 0xCC, 0xBE with `i_temp`=16'h0191 → two `o_cmd_vld` pulses; 16 read slots return 0x0191 LSB first. With `ONEWIRE_SLAVE_CRC_EN`, 8 further slots return the CRC computed over bytes 0x91, 0x01.
- Unknown command 0x55 → `o_cmd`=8'h55, then further read slots leave the bus released (all 1s).
- A 500 µs reset pulse during the 10th ROM bit → TX aborted, presence issued, a new 0x33 restarts the ROM from bit 0.
